// File: rtl/rd_burst_if.sv
// Bus bundle for rd_burst_scheduler: command intake, Avalon-MM read request and compare-block link.
// "master" is the scheduler side, "slave" is the environment (command source, AMM fabric, compare block).
interface rd_burst_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BURST_W = 11
);
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [ADDR_W-1:0]  cmd_addr_i;
    logic [BURST_W-1:0] cmd_words_i;
    logic [7:0]         cmd_ptrn_i;
    logic               cmd_rnd_i;

    logic               read_o;
    logic [ADDR_W-1:0]  address_o;
    logic [BURST_W-1:0] burstcount_o;
    logic               waitrequest_i;

    logic               cmp_en_o;
    logic [ADDR_W-1:0]  cmp_addr_o;
    logic [BURST_W-2:0] cmp_words_o;
    logic [7:0]         cmp_ptrn_o;
    logic               cmp_rnd_o;
    logic               word_done_i;
    logic               desc_done_i;
    logic               cmp_error_i;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_ptrn_i, cmd_rnd_i,
        output cmd_ready_o,
        output read_o, address_o, burstcount_o,
        input  waitrequest_i,
        output cmp_en_o, cmp_addr_o, cmp_words_o, cmp_ptrn_o, cmp_rnd_o,
        input  word_done_i, desc_done_i, cmp_error_i
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_ptrn_i, cmd_rnd_i,
        input  cmd_ready_o,
        input  read_o, address_o, burstcount_o,
        output waitrequest_i,
        input  cmp_en_o, cmp_addr_o, cmp_words_o, cmp_ptrn_o, cmp_rnd_o,
        output word_done_i, desc_done_i, cmp_error_i
    );
endinterface

// File: rtl/rd_burst_scheduler.sv
// Read-back burst scheduler: turns check commands into credit-gated AMM read bursts plus compare descriptors.
// Optional watchdog enabled by defining RD_SCHED_TIMEOUT_EN.
module rd_burst_scheduler #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned BURST_W      = 11,
    parameter int unsigned DATA_CREDITS = 64,
    parameter int unsigned DESC_CREDITS = 4
`ifdef RD_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC  = 4096
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_start_i,
    rd_burst_if.master        bus,
    output logic              busy_o,
    output logic              halted_o,
    output logic [31:0]       burst_cnt_o
);

    localparam int unsigned DC_W   = 8;
    localparam int unsigned DCN_W  = DC_W + 1;
    localparam int unsigned DS_W   = $clog2(DESC_CREDITS + 1);
    localparam int unsigned DSN_W  = DS_W + 1;
    localparam int unsigned CW_W   = BURST_W - 1;
    localparam int unsigned CMP_W  = (BURST_W > DC_W) ? BURST_W : DC_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_CR = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               read_q, read_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] words_q, words_d;
    logic [CW_W-1:0]    cmp_words_q, cmp_words_d;
    logic [7:0]         ptrn_q, ptrn_d;
    logic               rnd_q, rnd_d;
    logic [DC_W-1:0]    data_credit_q, data_credit_d;
    logic [DS_W-1:0]    desc_credit_q, desc_credit_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic [31:0]        burst_cnt_q, burst_cnt_d;
    logic               start_pend_q, start_pend_d;
    logic               stop_pend_q, stop_pend_d;

    logic               accept_c, stall_c, soft_rst_c, stop_c, timeout_c;
    logic               cmd_fire_c, oversize_c, credits_ok_c;
    logic [DCN_W-1:0]   dc_net_c;
    logic [DSN_W-1:0]   ds_net_c;

    assign accept_c     = read_q && !bus.waitrequest_i;
    assign stall_c      = read_q && bus.waitrequest_i;
    // A test start never cuts an AMM read short; it is deferred until the read is accepted.
    assign soft_rst_c   = (test_start_i || start_pend_q) && !stall_c;
    assign stop_c       = bus.cmp_error_i || timeout_c;
    assign cmd_fire_c   = bus.cmd_valid_i && cmd_ready_q;
    assign oversize_c   = bus.cmd_words_i > BURST_W'(DATA_CREDITS);
    assign credits_ok_c = (CMP_W'(data_credit_q) >= CMP_W'(words_q)) && (desc_credit_q != '0);

`ifdef RD_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wd_q, wd_d;

    // Watchdog counts cycles with read data outstanding but none returning.
    always_comb begin
        wd_d = wd_q;
        if (bus.word_done_i || test_start_i || (data_credit_q == DC_W'(DATA_CREDITS)))
            wd_d = '0;
        else if (!timeout_c)
            wd_d = wd_q + TO_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign timeout_c = (wd_q == TO_W'(TIMEOUT_CYC));
`else
    assign timeout_c = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        words_d       = words_q;
        cmp_words_d   = cmp_words_q;
        ptrn_d        = ptrn_q;
        rnd_d         = rnd_q;
        start_pend_d  = start_pend_q || (test_start_i && stall_c);
        stop_pend_d   = stop_pend_q;
        burst_cnt_d   = burst_cnt_q;
        if (accept_c)
            burst_cnt_d = burst_cnt_q + 32'd1;

        // Net credit update; returns beyond the initial credit are dropped.
        dc_net_c = DCN_W'(data_credit_q) - (accept_c ? DCN_W'(words_q) : DCN_W'(0));
        if (bus.word_done_i && (dc_net_c < DCN_W'(DATA_CREDITS)))
            dc_net_c = dc_net_c + DCN_W'(1);
        ds_net_c = DSN_W'(desc_credit_q) - (accept_c ? DSN_W'(1) : DSN_W'(0));
        if (bus.desc_done_i && (ds_net_c < DSN_W'(DESC_CREDITS)))
            ds_net_c = ds_net_c + DSN_W'(1);
        data_credit_d = DC_W'(dc_net_c);
        desc_credit_d = DS_W'(ds_net_c);

        case (state_q)
            S_IDLE: begin
                if (stop_c) begin
                    state_d = S_HALT;
                end else if (cmd_fire_c) begin
                    if (oversize_c) begin
                        state_d = S_HALT;
                    end else begin
                        addr_d      = bus.cmd_addr_i;
                        words_d     = bus.cmd_words_i;
                        cmp_words_d = CW_W'(bus.cmd_words_i - BURST_W'(1));
                        ptrn_d      = bus.cmd_ptrn_i;
                        rnd_d       = bus.cmd_rnd_i;
                        state_d     = S_WAIT_CR;
                    end
                end
            end
            S_WAIT_CR: begin
                if (stop_c)
                    state_d = S_HALT;
                else if (credits_ok_c)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // A stop request during a stalled read waits for the accept.
                if (accept_c) begin
                    state_d     = (stop_pend_q || stop_c) ? S_HALT : S_IDLE;
                    stop_pend_d = 1'b0;
                end else if (stop_c) begin
                    stop_pend_d = 1'b1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        read_d      = (state_d == S_ISSUE);
        halted_d    = (state_d == S_HALT);
        busy_d      = (state_q != S_HALT) &&
                      ((state_q != S_IDLE) || (data_credit_q != DC_W'(DATA_CREDITS)));

        if (soft_rst_c) begin
            state_d       = S_IDLE;
            cmd_ready_d   = 1'b0;
            read_d        = 1'b0;
            addr_d        = '0;
            words_d       = '0;
            cmp_words_d   = '0;
            ptrn_d        = '0;
            rnd_d         = 1'b0;
            data_credit_d = DC_W'(DATA_CREDITS);
            desc_credit_d = DS_W'(DESC_CREDITS);
            busy_d        = 1'b0;
            halted_d      = 1'b0;
            burst_cnt_d   = '0;
            start_pend_d  = 1'b0;
            stop_pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            read_q        <= 1'b0;
            addr_q        <= '0;
            words_q       <= '0;
            cmp_words_q   <= '0;
            ptrn_q        <= '0;
            rnd_q         <= 1'b0;
            data_credit_q <= DC_W'(DATA_CREDITS);
            desc_credit_q <= DS_W'(DESC_CREDITS);
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            burst_cnt_q   <= '0;
            start_pend_q  <= 1'b0;
            stop_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            read_q        <= read_d;
            addr_q        <= addr_d;
            words_q       <= words_d;
            cmp_words_q   <= cmp_words_d;
            ptrn_q        <= ptrn_d;
            rnd_q         <= rnd_d;
            data_credit_q <= data_credit_d;
            desc_credit_q <= desc_credit_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            burst_cnt_q   <= burst_cnt_d;
            start_pend_q  <= start_pend_d;
            stop_pend_q   <= stop_pend_d;
        end
    end

    assign bus.cmd_ready_o  = cmd_ready_q;
    assign bus.read_o       = read_q;
    assign bus.address_o    = addr_q;
    assign bus.burstcount_o = words_q;
    // Descriptor push coincides with the AMM accept, so it follows waitrequest directly.
    assign bus.cmp_en_o     = accept_c;
    assign bus.cmp_addr_o   = addr_q;
    assign bus.cmp_words_o  = cmp_words_q;
    assign bus.cmp_ptrn_o   = ptrn_q;
    assign bus.cmp_rnd_o    = rnd_q;
    assign busy_o           = busy_q;
    assign halted_o         = halted_q;
    assign burst_cnt_o      = burst_cnt_q;

endmodule

// File: tb/tb_rd_burst_scheduler.sv
// Directed testbench for rd_burst_scheduler with hand-computed expectations.
// Build with RD_SCHED_TIMEOUT_EN defined to exercise the watchdog variant.
module tb_rd_burst_scheduler;

    logic        clk_i;
    logic        rst_i;
    logic        test_start_i;
    logic        busy_o;
    logic        halted_o;
    logic [31:0] burst_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    int words_out;
    int descs_out;
    int waited;

    rd_burst_if #(.ADDR_W(32), .BURST_W(11)) bus ();

    rd_burst_scheduler #(
        .ADDR_W      (32),
        .BURST_W     (11),
        .DATA_CREDITS(64),
        .DESC_CREDITS(4)
`ifdef RD_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .test_start_i(test_start_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .halted_o    (halted_o),
        .burst_cnt_o (burst_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Present one command for exactly one accepted cycle; returns in the cycle after acceptance.
    task automatic send_cmd(input logic [31:0] addr, input logic [10:0] words,
                            input logic [7:0] ptrn, input logic rnd);
        int t;
        t = 0;
        while (!bus.cmd_ready_o && t < 50) begin
            cyc(1);
            t++;
        end
        if (!bus.cmd_ready_o) chk("cmd_ready_wait", 64'(bus.cmd_ready_o), 64'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = addr;
        bus.cmd_words_i = words;
        bus.cmd_ptrn_i  = ptrn;
        bus.cmd_rnd_i   = rnd;
        cyc(1);
        bus.cmd_valid_i = 1'b0;
    endtask

    // Wait (bounded) until the cycle in which a read is accepted.
    task automatic wait_accept(input int budget, output int n);
        n = 0;
        while (!(bus.read_o && !bus.waitrequest_i) && n < budget) begin
            cyc(1);
            n++;
        end
        if (!(bus.read_o && !bus.waitrequest_i)) chk("accept_wait", 64'd0, 64'd1);
    endtask

    task automatic ret(input int nw, input int nd);
        for (int i = 0; i < ((nw > nd) ? nw : nd); i++) begin
            bus.word_done_i = (i < nw);
            bus.desc_done_i = (i < nd);
            cyc(1);
        end
        bus.word_done_i = 1'b0;
        bus.desc_done_i = 1'b0;
    endtask

    // Compare-side legality: never return a word or descriptor that was not issued.
    always @(posedge clk_i) begin
        if (rst_i || (test_start_i && !(bus.read_o && bus.waitrequest_i))) begin
            words_out <= 0;
            descs_out <= 0;
        end else begin
            if (bus.word_done_i)
                chk("word_done_legal",
                    64'((words_out + (bus.cmp_en_o ? int'(bus.burstcount_o) : 0)) > 0), 64'd1);
            if (bus.desc_done_i)
                chk("desc_done_legal", 64'((descs_out + (bus.cmp_en_o ? 1 : 0)) > 0), 64'd1);
            words_out <= words_out + (bus.cmp_en_o ? int'(bus.burstcount_o) : 0)
                                   - (bus.word_done_i ? 1 : 0);
            descs_out <= descs_out + (bus.cmp_en_o ? 1 : 0) - (bus.desc_done_i ? 1 : 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; test_start_i = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_words_i = '0;
        bus.cmd_ptrn_i = '0; bus.cmd_rnd_i = 1'b0; bus.waitrequest_i = 1'b0;
        bus.word_done_i = 1'b0; bus.desc_done_i = 1'b0; bus.cmp_error_i = 1'b0;
        cyc(3);
        rst_i = 1'b0;

        // Reset state
        chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        chk("rst_read", 64'(bus.read_o), 64'd0);
        chk("rst_cmp_en", 64'(bus.cmp_en_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        chk("rst_burst_cnt", 64'(burst_cnt_o), 64'd0);
        chk("rst_addr_bc", {bus.address_o, 21'(bus.burstcount_o)}, 64'd0);
        chk("rst_cmp_fields", {bus.cmp_addr_o, 14'(bus.cmp_words_o), bus.cmp_ptrn_o, 2'(bus.cmp_rnd_o)}, 64'd0);
        chk("rst_data_credit", 64'(dut.data_credit_q), 64'd64);
        cyc(1);
        chk("idle_ready", 64'(bus.cmd_ready_o), 64'd1);

        // Single 4-word burst, 2-cycle command-to-read latency
        send_cmd(32'h100, 11'd4, 8'hA5, 1'b0);
        chk("t1_read_c1", 64'(bus.read_o), 64'd0);
        cyc(1);
        chk("t1_read_c2", 64'(bus.read_o), 64'd1);
        chk("t1_addr", 64'(bus.address_o), 64'h100);
        chk("t1_burstcount", 64'(bus.burstcount_o), 64'd4);
        chk("t1_cmp_en", 64'(bus.cmp_en_o), 64'd1);
        chk("t1_cmp_desc", {bus.cmp_addr_o, 14'(bus.cmp_words_o), bus.cmp_ptrn_o, 2'(bus.cmp_rnd_o)},
            {32'h100, 14'd3, 8'hA5, 2'd0});
        cyc(1);
        chk("t1_read_drop", {bus.read_o, bus.cmp_en_o, busy_o}, 3'b001);
        chk("t1_burst_cnt", 64'(burst_cnt_o), 64'd1);
        ret(4, 1);
        chk("t1_busy_hold", 64'(busy_o), 64'd1);
        cyc(1);
        chk("t1_busy_fall", 64'(busy_o), 64'd0);

        // Five 1-word commands, descriptor credit runs out after four
        for (int i = 0; i < 5; i++) begin
            send_cmd(32'h200 + 32'(i), 11'd1, 8'(i), 1'b0);
            if (i < 4) begin
                cyc(1);
                ret(1, 0);
            end
        end
        cyc(6);
        chk("t2_four_issued", 64'(burst_cnt_o), 64'd5);
        chk("t2_fifth_waits", {bus.read_o, bus.cmd_ready_o}, 2'b00);
        ret(0, 1);
        wait_accept(6, waited);
        chk("t2_release_lat", 64'(waited), 64'd1);
        chk("t2_fifth_addr", 64'(bus.address_o), 64'h204);
        bus.word_done_i = 1'b1;
        cyc(1);
        bus.word_done_i = 1'b0;
        chk("t2_burst_cnt", 64'(burst_cnt_o), 64'd6);
        ret(0, 4);

        // Two 40-word bursts, second needs 16 words returned
        send_cmd(32'h1000, 11'd40, 8'h01, 1'b0);
        send_cmd(32'h2000, 11'd40, 8'h02, 1'b0);
        cyc(4);
        chk("t3_first_only", 64'(burst_cnt_o), 64'd7);
        ret(15, 0);
        cyc(3);
        chk("t3_held_at_15", {bus.read_o, 32'(burst_cnt_o)}, {1'b0, 32'd7});
        ret(1, 0);
        wait_accept(6, waited);
        chk("t3_second_addr", 64'(bus.address_o), 64'h2000);
        cyc(1);
        chk("t3_burst_cnt", 64'(burst_cnt_o), 64'd8);
        ret(64, 2);
        cyc(2);
        chk("t3_busy_fall", 64'(busy_o), 64'd0);

        // Accept of 8 words together with one returned word: 64 - 8 + 1
        send_cmd(32'h3000, 11'd8, 8'h11, 1'b1);
        cyc(1);
        bus.word_done_i = 1'b1;
        chk("t5_cmp_en", 64'(bus.cmp_en_o), 64'd1);
        cyc(1);
        bus.word_done_i = 1'b0;
        chk("t5_data_credit", 64'(dut.data_credit_q), 64'd57);
        ret(7, 1);

        // Stalled read with compare error during the stall
        bus.waitrequest_i = 1'b1;
        send_cmd(32'h400, 11'd16, 8'h3C, 1'b1);
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall_stable", {1'b1, bus.read_o, bus.cmp_en_o, bus.address_o, 11'(bus.burstcount_o)},
                {1'b1, 1'b1, 1'b0, 32'h400, 11'd16});
            bus.cmp_error_i = (i == 3);
            cyc(1);
        end
        bus.cmp_error_i   = 1'b0;
        bus.waitrequest_i = 1'b0;
        #1;
        chk("t4_accept_desc", {bus.cmp_en_o, 14'(bus.cmp_words_o), bus.cmp_ptrn_o, bus.cmp_rnd_o},
            {1'b1, 14'd15, 8'h3C, 1'b1});
        cyc(1);
        chk("t4_halt", {bus.read_o, halted_o, bus.cmd_ready_o}, 3'b010);
        chk("t4_burst_cnt", 64'(burst_cnt_o), 64'd10);
        cyc(2);
        chk("t4_halt_busy", {halted_o, busy_o}, 2'b10);
        test_start_i = 1'b1;
        cyc(1);
        test_start_i = 1'b0;
        chk("t4_restart", {halted_o, 32'(burst_cnt_o), 8'(dut.data_credit_q), 8'(dut.desc_credit_q)},
            {1'b0, 32'd0, 8'd64, 8'd4});
        cyc(1);
        chk("t4_ready_again", 64'(bus.cmd_ready_o), 64'd1);

        // One burst, no data returned
        send_cmd(32'h500, 11'd2, 8'h00, 1'b0);
        wait_accept(4, waited);
        cyc(40);
`ifdef RD_SCHED_TIMEOUT_EN
        chk("t6_timeout_halt", 64'(halted_o), 64'd1);
`else
        chk("t6_no_timeout", 64'(halted_o), 64'd0);
`endif
        test_start_i = 1'b1;
        cyc(1);
        test_start_i = 1'b0;
        cyc(1);

        // Burst longer than the data credit pool is rejected into HALT
        send_cmd(32'h600, 11'd65, 8'h00, 1'b0);
        chk("t7_oversize_halt", {halted_o, bus.cmd_ready_o}, 2'b10);
        cyc(3);
        chk("t7_no_issue", {bus.read_o, 32'(burst_cnt_o)}, {1'b0, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
